// File: rtl/svc_rv_io_uart_tx.sv
// -----------------------------------------------------------------------------
// svc_rv_io_uart_tx
//
// Memory-mapped UART transmitter with a byte FIFO. Bytes written to TXDATA
// are queued and serialised 8N1 (start bit, 8 data bits LSB first, stop bit)
// on txd. Frames queued back to back leave no idle gap between them.
//
// Register map (only address bits [3:2] are decoded):
//   0x0 TXDATA  W: wstrb[0] pushes wdata[7:0]     R: 0
//   0x4 STATUS  R: [0] busy [1] full [2] overflow [15:8] FIFO count
//               W: wstrb[0] && wdata[2] clears overflow
//   0x8, 0xC    R: 0, writes ignored
//
// Ports:
//   clk       single clock
//   rst_n     asynchronous active-low reset
//   io_raddr  MMIO read address
//   io_rdata  MMIO read data, combinational from io_raddr
//   io_wen    MMIO write strobe
//   io_waddr  MMIO write address
//   io_wdata  MMIO write data
//   io_wstrb  MMIO byte enables
//   txd       registered serial output, idle high
// -----------------------------------------------------------------------------
module svc_rv_io_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        txd
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic wr_txdata;
  logic wr_ovf_clr;

  assign wr_txdata  = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
  assign wr_ovf_clr = io_wen && (io_waddr[3:2] == 2'd1) && io_wstrb[0] && io_wdata[2];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;
  logic [7:0]       head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  // A full FIFO still accepts a byte on the edge the transmitter pops one.
  assign push_ok    = wr_txdata && (!fifo_full || pop);
  assign push_drop  = wr_txdata && !push_ok;
  assign head       = mem[rptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr + PTR_W'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A dropped byte wins over a simultaneous clear.
      if (push_drop)       overflow <= 1'b1;
      else if (wr_ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count and
  // pointers alone, so clearing the bytes would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= io_wdata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t            state,    state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_idx,  bit_idx_n;
  logic [7:0]        shreg,    shreg_n;
  logic              txd_level;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      // txd is the registered copy of the current state's line level, so the
      // line trails the state by one clock.
      txd      <= txd_level;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    txd_level  = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_n    = head;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end

      START: begin
        txd_level = 1'b0;
        if (baud_done) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        txd_level = shreg[0];
        if (baud_done) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        txd_level = 1'b1;
        if (baud_done) begin
          baud_cnt_n = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic       busy;
  logic [7:0] status_count;

  assign busy         = !fifo_empty || (state != IDLE);
  assign status_count = 8'(count);

  always_comb begin
    io_rdata = '0;
    if (io_raddr[3:2] == 2'd1) begin
      io_rdata = {16'h0000, status_count, 5'b00000, overflow, fifo_full, busy};
    end
  end

  // Address bits above [3:2] are decoded upstream; only the low byte of the
  // write data and byte lane 0 carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4],
                         io_waddr[1:0], io_wdata[31:8], io_wstrb[3:1]};

endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_svc_rv_io_uart_tx
//
// Self-checking bench for svc_rv_io_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-based reference model predicts txd and every register read; a
// compare process checks them each falling edge. Directed sequences pin the
// model with hand-computed waveforms and STATUS words, then a randomized
// phase exercises the bus.
// -----------------------------------------------------------------------------
module tb_svc_rv_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        txd;

  int total = 0;
  int bad   = 0;

  svc_rv_io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a byte queue plus a frame timer counting clocks since the
  // frame's pop edge. exp_txd is the line level after the most recent edge.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_frame  = 8'h00;
  int         m_t      = 0;
  bit         m_active = 1'b0;
  bit         m_ovf    = 1'b0;
  logic       exp_txd  = 1'b1;

  function automatic logic m_level();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_t / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_frame[slot-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[3:2] == 2'd1) begin
      r[0]    = m_active || (m_q.size() > 0);
      r[1]    = (m_q.size() == DEPTH);
      r[2]    = m_ovf;
      r[15:8] = 8'(m_q.size());
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  pre;
    bit  popped;
    bit  push_req;
    bit  clr;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      exp_txd  = 1'b1;
    end else begin
      pre      = m_q.size();
      popped   = 1'b0;
      push_req = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
      clr      = io_wen && (io_waddr[3:2] == 2'd1) && io_wstrb[0] && io_wdata[2];
      exp_txd  = m_level();
      if (m_active) begin
        m_t++;
        if (m_t == 10 * CPB) m_active = 1'b0;
      end
      if (!m_active && pre > 0) begin
        m_frame  = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
        popped   = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
      if (push_req) begin
        if (pre < DEPTH || popped) m_q.push_back(io_wdata[7:0]);
        else                       m_ovf = 1'b1;
      end
    end
  end

  // Continuous compare against the model, away from the rising edge.
  always @(negedge clk) begin
    check("txd_model", 64'(txd), 64'(exp_txd));
    check("rdata_model", 64'(io_rdata), 64'(m_read(io_raddr)));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each step returns 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    io_wen   = 1'b0;
    io_waddr = 32'h0;
    io_wdata = 32'h0;
    io_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    io_wen   = 1'b1;
    io_waddr = a;
    io_wdata = d;
    io_wstrb = s;
    step();
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_raddr = a;
    #1;
    d = io_rdata;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n;
    n = 0;
    rd(32'h4, st);
    while (st[0] && n < 2000) begin
      step();
      rd(32'h4, st);
      n++;
    end
    check("wait_idle_busy", 64'(st[0]), 64'(0));
  endtask

  // Stretch a 10-slot frame literal (bit i = line level of slot i) to CPB
  // clocks per slot.
  function automatic logic [39:0] expand(input logic [9:0] lit);
    logic [39:0] v;
    for (int i = 0; i < 40; i++) v[i] = lit[i / CPB];
    return v;
  endfunction

  // Frame literals, slot 0 = start bit, slots 1..8 = data LSB first, 9 = stop.
  localparam logic [9:0] LIT_55 = 10'b1010101010;
  localparam logic [9:0] LIT_A5 = 10'b1101001010;
  localparam logic [9:0] LIT_3C = 10'b1001111000;

  logic [31:0]  st;
  logic [127:0] tv;
  logic [127:0] bv;
  int           n;
  int           r;
  int           pct;

  initial begin
    rst_n    = 1'b1;
    io_raddr = 32'h4;
    idle_bus();
    #1 rst_n = 1'b0;

    // Reset state
    step();
    step();
    rd(32'h4, st);
    check("reset_status", 64'(st), 64'h0);
    check("reset_txd", 64'(txd), 64'h1);
    rst_n = 1'b1;
    step();
    rd(32'h4, st);
    check("post_reset_status", 64'(st), 64'h0);

    // Single byte 0x55
    wr(32'h0, 32'h55, 4'b0001);
    for (int k = 0; k < 42; k++) begin
      tv[k] = txd;
      rd(32'h4, st);
      bv[k] = st[0];
      if (k == 41) check("single_status_after", 64'(st), 64'h0);
      step();
    end
    check("single_txd", 64'(tv[41:0]), 64'({expand(LIT_55), 2'b11}));
    check("single_busy", 64'(bv[41:0]), 64'({1'b0, {41{1'b1}}}));

    // Back to back 0xA5, 0x3C
    io_wen = 1'b1; io_waddr = 32'h0; io_wstrb = 4'b0001; io_wdata = 32'hA5;
    step();
    io_wdata = 32'h3C;
    step();
    idle_bus();
    for (int k = 1; k <= 82; k++) begin
      tv[k] = txd;
      rd(32'h4, st);
      if (k == 80) check("b2b_busy_last", 64'(st[0]), 64'h1);
      if (k == 81) check("b2b_status_after", 64'(st), 64'h0);
      step();
    end
    check("b2b_frame0", 64'(tv[41:2]), 64'(expand(LIT_A5)));
    check("b2b_frame1", 64'(tv[81:42]), 64'(expand(LIT_3C)));
    check("b2b_idle_after", 64'(tv[82]), 64'h1);

    // Overflow: 6 pushes on consecutive edges
    for (int i = 0; i < 6; i++) begin
      io_wen = 1'b1; io_waddr = 32'h0; io_wstrb = 4'b0001; io_wdata = 32'(8'h10 + i);
      step();
    end
    idle_bus();
    rd(32'h4, st);
    check("ovf_status", 64'(st), 64'h407);
    n = 0;
    while (st[0] && n < 1000) begin
      n++;
      step();
      rd(32'h4, st);
    end
    check("ovf_busy_cycles", 64'(n), 64'd196);
    check("ovf_status_after", 64'(st), 64'h4);

    // Overflow clear
    wr(32'h4, 32'h4, 4'b0001);
    rd(32'h4, st);
    check("ovf_clear_idle", 64'(st), 64'h0);
    for (int i = 0; i < 6; i++) begin
      io_wen = 1'b1; io_waddr = 32'h0; io_wstrb = 4'b0001; io_wdata = 32'(8'h20 + i);
      step();
    end
    idle_bus();
    wr(32'h4, 32'h4, 4'b0001);
    rd(32'h4, st);
    check("ovf_clear_full", 64'(st), 64'h403);
    wr(32'h0, 32'h99, 4'b0001);
    rd(32'h4, st);
    check("ovf_reset_by_drop", 64'(st), 64'h407);
    wr(32'h4, 32'h4, 4'b1110);
    rd(32'h4, st);
    check("ovf_clear_needs_strb0", 64'(st), 64'h407);
    wr(32'h4, 32'h4, 4'b0001);
    rd(32'h4, st);
    check("ovf_clear_again", 64'(st), 64'h403);

    // Reset mid-frame during DATA bit 3 (also discards the queued bytes)
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wr(32'h0, 32'h00, 4'b0001);
    wr(32'h0, 32'hFF, 4'b0001);
    for (int i = 0; i < 18; i++) step();
    check("pre_reset_txd", 64'(txd), 64'h0);
    #1 rst_n = 1'b0;
    #1 check("async_reset_txd", 64'(txd), 64'h1);
    rd(32'h4, st);
    check("reset_mid_status", 64'(st), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      rd(32'h4, st);
      if (txd !== 1'b1 || st !== 32'h0) check("post_reset_quiet", 64'({txd, st}), 64'({1'b1, 32'h0}));
    end
    check("post_reset_final", 64'({txd, st}), 64'({1'b1, 32'h0}));

    // Decode
    wr(32'h0, 32'h77, 4'b1110);
    rd(32'h4, st);
    check("dec_no_push", 64'(st), 64'h0);
    wr(32'h8, 32'hFFFF_FFFF, 4'hF);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(32'h4, st);
    check("dec_ignore_8c", 64'(st), 64'h0);
    wr(32'h0, 32'h12, 4'b0001);
    rd(32'h8000_0014, st);
    check("dec_alias_status", 64'(st), 64'h101);
    rd(32'h8, st);
    check("dec_read_8", 64'(st), 64'h0);
    rd(32'hC, st);
    check("dec_read_c", 64'(st), 64'h0);
    rd(32'h0, st);
    check("dec_read_0", 64'(st), 64'h0);
    step();
    rd(32'h4, st);
    check("dec_after_pop", 64'(st), 64'h1);
    wait_idle();

    // Randomized traffic, alternating light and heavy push phases
    for (int i = 0; i < 4000; i++) begin
      pct      = ((i / 500) % 2) ? 30 : 6;
      r        = $urandom_range(0, 99);
      io_raddr = $urandom();
      io_waddr = $urandom();
      io_wdata = $urandom();
      io_wstrb = 4'($urandom_range(0, 15));
      io_wen   = 1'b0;
      if (r < pct) begin
        io_wen        = 1'b1;
        io_waddr[3:2] = 2'd0;
        io_wstrb[0]   = (r != 0);
      end else if (r < pct + 3) begin
        io_wen        = 1'b1;
        io_waddr[3:2] = 2'd1;
      end else if (r < pct + 5) begin
        io_wen        = 1'b1;
        io_waddr[3:2] = 2'(2 + (r % 2));
      end
      if (i == 2000) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    idle_bus();
    io_raddr = 32'h4;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
